palette_ram_mp: RTL and testbench

PALETTE_RAM_MP -- requirements
Module: palette_ram_mp

---
 rtl/palette_pkg.sv | 30 +++
 rtl/palette_bank.sv | 51 +++++
 rtl/palette_ram_mp.sv | 168 ++++++++++++++++
 tb/tb_palette_ram_mp.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_pkg.sv
// palette_pkg
//   Shared definitions for the multi-port palette RAM.
//   - state_e     : sequencer states (IDLE, INIT)
//   - DEFAULT_LEN : number of entries in the built-in default palette
//   - DEFAULT     : default palette, 12-bit 0RGB values
//   - default_rgb : table lookup returning 0 beyond DEFAULT_LEN
package palette_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      INIT = 1'b1
   } state_e;

   localparam int DEFAULT_LEN = 16;

   localparam logic [11:0] DEFAULT [DEFAULT_LEN] = '{
      12'h000, 12'hFFF, 12'h800, 12'hAFE,
      12'hC4C, 12'h0C5, 12'h00A, 12'hEE7,
      12'hD85, 12'h640, 12'hF77, 12'h333,
      12'h777, 12'hAF6, 12'h08F, 12'hBBB
   };

   function automatic logic [11:0] default_rgb(input int unsigned idx);
      if (idx < DEFAULT_LEN) begin
         return DEFAULT[idx[3:0]];
      end
      return 12'h000;
   endfunction

endpackage

// File: rtl/palette_bank.sv
// palette_bank
//   One replica of the palette storage: one byte-enabled write port and one
//   read port with a single registered read stage (read-old-data on a
//   same-address collision).
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset (read register only)
//     wr_en, ben        write strobe and per-byte enables
//     wr_addr, wr_data  write address / data
//     rd_en, rd_addr    read strobe / address
//     rd_data           registered read data, held while rd_en is low
module palette_bank #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [DATA_W/8-1:0] ben,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                rd_en,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [DATA_W-1:0]   rd_data
);

   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;

   // Storage has no reset; contents come from the init load.
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (ben[b]) begin
               mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end
   end

   // ---- read stage p0 -> p1 ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/palette_ram_mp.sv
// palette_ram_mp
//   Multi-read-port palette RAM with a default-palette init sequencer.
//   One palette_bank replica per read port; every write (host or init)
//   goes to all replicas. Optional write-to-read forwarding.
//   Ports:
//     clk_i, rst_n_i          clock, asynchronous active-low reset
//     init_i                  restart default-palette load
//     busy_o                  init load running, host writes refused
//     wr_en_i, ben_i          host write strobe, byte enables
//     wr_addr_i, wr_data_i    host write address / data
//     wr_drop_o               sticky "host write refused" flag
//     wr_drop_clr_i           clears wr_drop_o (a same-cycle set wins)
//     rd_en_i                 per-port read strobe
//     rd_addr_i, rd_data_o    per-port address / data, port k in slice k
module palette_ram_mp
   import palette_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int NRD    = 2,
   parameter int BYPASS = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  init_i,
   output logic                  busy_o,
   input  logic                  wr_en_i,
   input  logic [DATA_W/8-1:0]   ben_i,
   input  logic [ADDR_W-1:0]     wr_addr_i,
   input  logic [DATA_W-1:0]     wr_data_i,
   output logic                  wr_drop_o,
   input  logic                  wr_drop_clr_i,
   input  logic [NRD-1:0]        rd_en_i,
   input  logic [NRD*ADDR_W-1:0] rd_addr_i,
   output logic [NRD*DATA_W-1:0] rd_data_o
);

   localparam int NB = DATA_W / 8;

   function automatic logic [DATA_W-1:0] byte_mask(input logic [NB-1:0] b);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int i = 0; i < NB; i++) begin
         m[i*8 +: 8] = {8{b[i]}};
      end
      return m;
   endfunction

   // 12-bit 0RGB zero-extended or truncated to the entry width.
   function automatic logic [DATA_W-1:0] default_word(input logic [ADDR_W-1:0] a);
      return DATA_W'(default_rgb(int'(a)));
   endfunction

   state_e            state;
   logic [ADDR_W-1:0] init_addr;

   logic              we_p0;
   logic [NB-1:0]     wben_p0;
   logic [DATA_W-1:0] wmask_p0;
   logic [ADDR_W-1:0] waddr_p0;
   logic [DATA_W-1:0] wdata_p0;

   // Sequencer, busy and drop flag. busy_o mirrors state == INIT but is
   // registered so it is clean at the port.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= INIT;
         init_addr <= '0;
         busy_o    <= 1'b1;
         wr_drop_o <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               if (init_i) begin
                  init_addr <= '0;
               end else if (init_addr == '1) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end else begin
                  init_addr <= init_addr + 1'b1;
               end
            end
            default: begin
               if (init_i) begin
                  state     <= INIT;
                  init_addr <= '0;
                  busy_o    <= 1'b1;
               end
            end
         endcase

         if (busy_o && wr_en_i && (|ben_i)) begin
            wr_drop_o <= 1'b1;
         end else if (wr_drop_clr_i) begin
            wr_drop_o <= 1'b0;
         end
      end
   end

   // Write mux: the init load owns the write port while INIT.
   always_comb begin
      we_p0    = 1'b0;
      wben_p0  = '0;
      waddr_p0 = wr_addr_i;
      wdata_p0 = wr_data_i;
      if (state == INIT) begin
         we_p0    = 1'b1;
         wben_p0  = '1;
         waddr_p0 = init_addr;
         wdata_p0 = default_word(init_addr);
      end else if (wr_en_i && (|ben_i)) begin
         we_p0   = 1'b1;
         wben_p0 = ben_i;
      end
   end

   assign wmask_p0 = byte_mask(wben_p0);

   for (genvar k = 0; k < NRD; k++) begin : g_port
      logic [ADDR_W-1:0] raddr_p0;
      logic              hit_p0;
      logic [DATA_W-1:0] bank_q_p1;
      logic              hit_p1;
      logic [DATA_W-1:0] fwd_mask_p1;
      logic [DATA_W-1:0] fwd_data_p1;

      assign raddr_p0 = rd_addr_i[k*ADDR_W +: ADDR_W];
      assign hit_p0   = (BYPASS != 0) && we_p0 && (waddr_p0 == raddr_p0);

      palette_bank #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_bank (
         .clk     (clk_i),
         .rst_n   (rst_n_i),
         .wr_en   (we_p0),
         .ben     (wben_p0),
         .wr_addr (waddr_p0),
         .wr_data (wdata_p0),
         .rd_en   (rd_en_i[k]),
         .rd_addr (raddr_p0),
         .rd_data (bank_q_p1)
      );

      // ---- forwarding stage p0 -> p1 ----
      // The bank returns pre-write data; the captured write bytes are
      // merged on top of it when the read collided with a write.
      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            hit_p1 <= 1'b0;
         end else if (rd_en_i[k]) begin
            hit_p1 <= hit_p0;
         end
      end

      always_ff @(posedge clk_i) begin
         if (rd_en_i[k]) begin
            fwd_mask_p1 <= wmask_p0;
            fwd_data_p1 <= wdata_p0;
         end
      end

      assign rd_data_o[k*DATA_W +: DATA_W] =
         hit_p1 ? ((bank_q_p1 & ~fwd_mask_p1) | (fwd_data_p1 & fwd_mask_p1))
                : bank_q_p1;
   end

endmodule

// File: tb/tb_palette_ram_mp.sv
// tb_palette_ram_mp
//   Directed bench for palette_ram_mp. Two instances share all inputs:
//   dut (BYPASS=1) and dut_nb (BYPASS=0), both DATA_W=16, ADDR_W=8, NRD=2.
module tb_palette_ram_mp;

   logic        clk;
   logic        rst_n;
   logic        init;
   logic        wr_en;
   logic [1:0]  ben;
   logic [7:0]  wr_addr;
   logic [15:0] wr_data;
   logic        wr_drop_clr;
   logic [1:0]  rd_en;
   logic [15:0] rd_addr;

   logic        busy,    busy_nb;
   logic        drop,    drop_nb;
   logic [31:0] rd_data, rd_data_nb;

   int vectors;
   int errors;

   palette_ram_mp #(.DATA_W(16), .ADDR_W(8), .NRD(2), .BYPASS(1)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .init_i(init), .busy_o(busy),
      .wr_en_i(wr_en), .ben_i(ben), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .wr_drop_o(drop), .wr_drop_clr_i(wr_drop_clr),
      .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data)
   );

   palette_ram_mp #(.DATA_W(16), .ADDR_W(8), .NRD(2), .BYPASS(0)) dut_nb (
      .clk_i(clk), .rst_n_i(rst_n), .init_i(init), .busy_o(busy_nb),
      .wr_en_i(wr_en), .ben_i(ben), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .wr_drop_o(drop_nb), .wr_drop_clr_i(wr_drop_clr),
      .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      ben     = b;
      step();
      wr_en = 1'b0;
      ben   = 2'b00;
   endtask

   task automatic read1(input int k, input logic [7:0] a,
                        output logic [15:0] d, output logic [15:0] dnb);
      rd_en[k]          = 1'b1;
      rd_addr[k*8 +: 8] = a;
      step();
      rd_en = 2'b00;
      d     = rd_data[k*16 +: 16];
      dnb   = rd_data_nb[k*16 +: 16];
   endtask

   // Counts cycles with busy high, bounded at 400.
   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 400) begin
         n++;
         step();
      end
   endtask

   task automatic test_reset();
      int n;
      logic [15:0] d, dnb;
      rst_n = 1'b0;
      repeat (3) step();
      vectors++;
      if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
      vectors++;
      if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b want 0", drop); end
      vectors++;
      if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 00000000", rd_data); end
      rst_n = 1'b1;
      wait_idle(n);
      vectors++;
      if (n !== 256) begin errors++; $display("FAIL reset_busy_cycles: got %0d want 256", n); end
      read1(0, 8'd1, d, dnb);
      vectors++;
      if (d !== 16'h0FFF) begin errors++; $display("FAIL rd_addr1: got %h want 0fff", d); end
      read1(1, 8'd3, d, dnb);
      vectors++;
      if (d !== 16'h0AFE) begin errors++; $display("FAIL rd_addr3_p1: got %h want 0afe", d); end
      vectors++;
      if (dnb !== 16'h0AFE) begin errors++; $display("FAIL rd_addr3_p1_nb: got %h want 0afe", dnb); end
      read1(0, 8'd200, d, dnb);
      vectors++;
      if (d !== 16'h0000) begin errors++; $display("FAIL rd_addr200: got %h want 0000", d); end
      vectors++;
      if (rd_data[31:16] !== 16'h0AFE) begin errors++; $display("FAIL rd_hold_p1: got %h want 0afe", rd_data[31:16]); end
   endtask

   task automatic test_byte_enables();
      logic [15:0] d, dnb;
      host_write(8'd5, 16'hABCD, 2'b11);
      host_write(8'd5, 16'h12FF, 2'b01);
      read1(0, 8'd5, d, dnb);
      vectors++;
      if (d !== 16'hABFF) begin errors++; $display("FAIL ben_merge: got %h want abff", d); end
      host_write(8'd5, 16'h0000, 2'b00);
      read1(1, 8'd5, d, dnb);
      vectors++;
      if (d !== 16'hABFF) begin errors++; $display("FAIL ben_zero_noop: got %h want abff", d); end
      vectors++;
      if (drop !== 1'b0) begin errors++; $display("FAIL idle_no_drop: got %b want 0", drop); end
   endtask

   task automatic test_bypass();
      logic [15:0] d, dnb;
      host_write(8'd7, 16'h0000, 2'b11);
      wr_en = 1'b1; wr_addr = 8'd7; wr_data = 16'h1234; ben = 2'b11;
      rd_en = 2'b01; rd_addr[7:0] = 8'd7;
      step();
      wr_en = 1'b0; ben = 2'b00; rd_en = 2'b00;
      vectors++;
      if (rd_data[15:0] !== 16'h1234) begin errors++; $display("FAIL bypass1_full: got %h want 1234", rd_data[15:0]); end
      vectors++;
      if (rd_data_nb[15:0] !== 16'h0000) begin errors++; $display("FAIL bypass0_full: got %h want 0000", rd_data_nb[15:0]); end
      read1(0, 8'd7, d, dnb);
      vectors++;
      if (d !== 16'h1234) begin errors++; $display("FAIL bypass1_next: got %h want 1234", d); end
      vectors++;
      if (dnb !== 16'h1234) begin errors++; $display("FAIL bypass0_next: got %h want 1234", dnb); end
      wr_en = 1'b1; wr_addr = 8'd7; wr_data = 16'h56AA; ben = 2'b10;
      rd_en = 2'b10; rd_addr[15:8] = 8'd7;
      step();
      wr_en = 1'b0; ben = 2'b00; rd_en = 2'b00;
      vectors++;
      if (rd_data[31:16] !== 16'h5634) begin errors++; $display("FAIL bypass1_partial: got %h want 5634", rd_data[31:16]); end
      vectors++;
      if (rd_data_nb[31:16] !== 16'h1234) begin errors++; $display("FAIL bypass0_partial: got %h want 1234", rd_data_nb[31:16]); end
   endtask

   task automatic test_write_busy();
      int n;
      logic [15:0] d, dnb;
      rst_n = 1'b0;
      #2;
      vectors++;
      if (rd_data !== 32'h0) begin errors++; $display("FAIL async_reset_rd: got %h want 00000000", rd_data); end
      vectors++;
      if (busy !== 1'b1) begin errors++; $display("FAIL async_reset_busy: got %b want 1", busy); end
      step();
      rst_n = 1'b1;
      repeat (10) step();
      host_write(8'd3, 16'h5555, 2'b11);
      vectors++;
      if (drop !== 1'b1) begin errors++; $display("FAIL drop_set: got %b want 1", drop); end
      wr_drop_clr = 1'b1;
      host_write(8'd4, 16'h6666, 2'b01);
      wr_drop_clr = 1'b0;
      vectors++;
      if (drop !== 1'b1) begin errors++; $display("FAIL drop_set_wins: got %b want 1", drop); end
      wr_drop_clr = 1'b1;
      step();
      wr_drop_clr = 1'b0;
      vectors++;
      if (drop !== 1'b0) begin errors++; $display("FAIL drop_clear: got %b want 0", drop); end
      wait_idle(n);
      vectors++;
      if (n !== 243) begin errors++; $display("FAIL busy_remaining: got %0d want 243", n); end
      read1(0, 8'd3, d, dnb);
      vectors++;
      if (d !== 16'h0AFE) begin errors++; $display("FAIL refused_addr3: got %h want 0afe", d); end
      read1(1, 8'd4, d, dnb);
      vectors++;
      if (d !== 16'h0C4C) begin errors++; $display("FAIL refused_addr4: got %h want 0c4c", d); end
      // reset landing on a host write restarts the load from address 0
      rst_n = 1'b0;
      wr_en = 1'b1; wr_addr = 8'd9; wr_data = 16'h7777; ben = 2'b11;
      step();
      rst_n = 1'b1; wr_en = 1'b0; ben = 2'b00;
      wait_idle(n);
      vectors++;
      if (n !== 256) begin errors++; $display("FAIL midwrite_reset_cycles: got %0d want 256", n); end
      read1(0, 8'd9, d, dnb);
      vectors++;
      if (d !== 16'h0640) begin errors++; $display("FAIL midwrite_reset_addr9: got %h want 0640", d); end
   endtask

   task automatic test_init_restart();
      int n;
      host_write(8'd0, 16'h1111, 2'b11);
      host_write(8'd15, 16'h2222, 2'b11);
      init = 1'b1;
      step();
      init = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin errors++; $display("FAIL init_enter: got %b want 1", busy); end
      repeat (15) step();
      rd_en = 2'b10; rd_addr[15:8] = 8'd15;
      step();
      rd_en = 2'b00;
      vectors++;
      if (rd_data[31:16] !== 16'h0BBB) begin errors++; $display("FAIL init_bypass1: got %h want 0bbb", rd_data[31:16]); end
      vectors++;
      if (rd_data_nb[31:16] !== 16'h2222) begin errors++; $display("FAIL init_bypass0: got %h want 2222", rd_data_nb[31:16]); end
      repeat (84) step();
      init = 1'b1;
      step();
      init = 1'b0;
      wait_idle(n);
      vectors++;
      if (n !== 256) begin errors++; $display("FAIL restart_cycles: got %0d want 256", n); end
      rd_en = 2'b11; rd_addr = {8'd15, 8'd0};
      step();
      rd_en = 2'b00;
      vectors++;
      if (rd_data[15:0] !== 16'h0000) begin errors++; $display("FAIL restart_p0_addr0: got %h want 0000", rd_data[15:0]); end
      vectors++;
      if (rd_data[31:16] !== 16'h0BBB) begin errors++; $display("FAIL restart_p1_addr15: got %h want 0bbb", rd_data[31:16]); end
   endtask

   initial begin
      vectors     = 0;
      errors      = 0;
      rst_n       = 1'b0;
      init        = 1'b0;
      wr_en       = 1'b0;
      ben         = 2'b00;
      wr_addr     = 8'd0;
      wr_data     = 16'h0;
      wr_drop_clr = 1'b0;
      rd_en       = 2'b00;
      rd_addr     = 16'h0;
      #1;
      test_reset();
      test_byte_enables();
      test_bypass();
      test_write_busy();
      test_init_restart();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
